// File: rtl/rr_arb4_merge_pkg.sv
// Shared arbiter types for the 4-way round-robin merge: requester count, index type,
// and modulo-4 index arithmetic used by the picker and the pointer update.
package misc_pkg;

  localparam int ARB4_N     = 4;
  localparam int ARB4_IDX_W = 2;

  typedef logic [ARB4_IDX_W-1:0] arb4_idx_t;

  // Index arithmetic wraps naturally in the 2-bit type (3 + 1 -> 0).
  function automatic arb4_idx_t rr_idx(input arb4_idx_t base, input int unsigned off);
    return base + arb4_idx_t'(off);
  endfunction

endpackage

// File: rtl/rr_arb4_merge_if.sv
// Request/output bundle of rr_arb4_merge; req_lock exists only when RR_ARB4_LOCK_EN is defined.
// slave = arbiter side, master = requesters/downstream side.
interface rr_arb4_merge_if
  import misc_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic [ARB4_N-1:0] req_valid;
  logic [WIDTH-1:0]  req_data0;
  logic [WIDTH-1:0]  req_data1;
  logic [WIDTH-1:0]  req_data2;
  logic [WIDTH-1:0]  req_data3;
  logic [ARB4_N-1:0] req_ready;
  arb4_idx_t         sel;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  arb4_idx_t         out_idx;
  logic              out_ready;
`ifdef RR_ARB4_LOCK_EN
  logic [ARB4_N-1:0] req_lock;
`endif

  modport slave (
    input  req_valid, req_data0, req_data1, req_data2, req_data3, out_ready,
`ifdef RR_ARB4_LOCK_EN
    input  req_lock,
`endif
    output req_ready, sel, out_valid, out_data, out_idx
  );

  modport master (
    output req_valid, req_data0, req_data1, req_data2, req_data3, out_ready,
`ifdef RR_ARB4_LOCK_EN
    output req_lock,
`endif
    input  req_ready, sel, out_valid, out_data, out_idx
  );

endinterface

// File: rtl/mux4.sv
// 4:1 datapath multiplexer cell driven by the arbiter's sel.
module mux4 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  input  logic [WIDTH-1:0] i_d3,
  input  logic [1:0]       i_s,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    unique case (i_s)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/rr_grant4.sv
// Rotate-priority picker: first valid requester starting at ptr, wrapping mod 4.
// With no valid request the grant is empty and sel reports ptr.
module rr_grant4
  import misc_pkg::*;
(
  input  logic [ARB4_N-1:0] i_req_valid,
  input  arb4_idx_t         i_ptr,
  output logic [ARB4_N-1:0] o_grant,
  output arb4_idx_t         o_sel
);

  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    o_grant = '0;
    o_sel   = i_ptr;
    // Scan from farthest to nearest so the closest valid requester overwrites last.
    for (int k = ARB4_N - 1; k >= 0; k--) begin
      if (i_req_valid[rr_idx(i_ptr, k)]) begin
        o_grant                   = '0;
        o_grant[rr_idx(i_ptr, k)] = 1'b1;
        o_sel                     = rr_idx(i_ptr, k);
      end
    end
  end

endmodule

// File: rtl/rr_arb4_merge.sv
// 4-requester round-robin arbiter with a 1-entry output register (full throughput).
// Optional burst lock: define RR_ARB4_LOCK_EN to add req_lock to the bus interface.
module rr_arb4_merge
  import misc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_aL,
  rr_arb4_merge_if.slave bus
);

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  arb4_idx_t         r_out_idx;
  arb4_idx_t         r_ptr;

  logic              w_load_en;
  logic              w_any_req;
  logic [ARB4_N-1:0] w_grant;
  arb4_idx_t         w_sel;
  arb4_idx_t         w_ptr_next;
  logic [WIDTH-1:0]  w_mux;

  rr_grant4 u_grant (
    .i_req_valid (bus.req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_sel       (w_sel)
  );

  mux4 #(.WIDTH(WIDTH)) u_mux (
    .i_d0 (bus.req_data0),
    .i_d1 (bus.req_data1),
    .i_d2 (bus.req_data2),
    .i_d3 (bus.req_data3),
    .i_s  (w_sel),
    .o_y  (w_mux)
  );

  // The register can take a new beat when empty or when it drains on this same edge.
  assign w_load_en = ~r_out_valid | bus.out_ready;
  assign w_any_req = |bus.req_valid;

`ifdef RR_ARB4_LOCK_EN
  assign w_ptr_next = bus.req_lock[w_sel] ? w_sel : rr_idx(w_sel, 1);
`else
  assign w_ptr_next = rr_idx(w_sel, 1);
`endif

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_aL) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_ptr       <= '0;
    end else if (w_load_en) begin
      if (w_any_req) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux;
        r_out_idx   <= w_sel;
        r_ptr       <= w_ptr_next;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready = rst_aL ? ({ARB4_N{w_load_en}} & w_grant) : '0;
  assign bus.sel       = w_sel;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_idx   = r_out_idx;

endmodule

// File: tb/tb_rr_arb4_merge.sv
// Bench for rr_arb4_merge: directed vector table, random traffic against a queue-free
// priority-search model, and a burst-lock sequence when RR_ARB4_LOCK_EN is defined.
module tb_rr_arb4_merge;
  import misc_pkg::*;

  localparam int WIDTH = 32;

  logic clk    = 1'b0;
  logic rst_aL = 1'b0;

  rr_arb4_merge_if #(.WIDTH(WIDTH)) bus ();

  rr_arb4_merge #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_aL (rst_aL),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_ptr;
  bit          m_ov;
  logic [31:0] m_data;
  int          m_idx;
  logic [3:0]  lock_drv;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic        ordy;
    logic [3:0]  exp_rr;
    logic [1:0]  exp_sel;
    logic        exp_ov;
    logic [1:0]  exp_idx;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic o,
                              input logic [3:0] rr, input logic [1:0] s, input logic ov,
                              input logic [1:0] idx, input logic [31:0] d);
    vec_t x;
    x.rst_n = r;  x.valid = v;  x.ordy = o;  x.exp_rr = rr;  x.exp_sel = s;
    x.exp_ov = ov; x.exp_idx = idx; x.exp_data = d;
    return x;
  endfunction

  task automatic drive(input logic r, input logic [3:0] v, input logic o, input logic [3:0] lk);
    rst_aL        = r;
    bus.req_valid = v;
    bus.out_ready = o;
`ifdef RR_ARB4_LOCK_EN
    bus.req_lock  = lk;
    lock_drv      = lk;
`else
    lock_drv      = (lk & 4'b0000);
`endif
  endtask

  task automatic set_data(input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
    bus.req_data0 = d0;
    bus.req_data1 = d1;
    bus.req_data2 = d2;
    bus.req_data3 = d3;
  endtask

  // One clock against the model: checks combinational outputs, then registered ones.
  task automatic mstep(input string tag);
    int          g;
    bit          le;
    logic        r;
    logic [31:0] d [4];
    logic [3:0]  exp_rr;
    #1;
    r    = rst_aL;
    d[0] = bus.req_data0; d[1] = bus.req_data1; d[2] = bus.req_data2; d[3] = bus.req_data3;
    le   = !m_ov || bus.out_ready;
    g    = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && bus.req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    end
    exp_rr = (r && le && g >= 0) ? (4'b0001 << g) : 4'b0000;
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'(exp_rr));
    check({tag, "_sel"}, 32'(bus.sel), (g < 0) ? m_ptr : g);
    @(posedge clk);
    if (!r) begin
      m_ov = 0; m_data = '0; m_idx = 0; m_ptr = 0;
    end else if (le) begin
      if (g >= 0) begin
        m_ov   = 1;
        m_data = d[g];
        m_idx  = g;
        m_ptr  = lock_drv[g] ? g : (g + 1) % 4;
      end else begin
        m_ov = 0;
      end
    end
    #1;
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(m_ov));
    check({tag, "_out_idx"}, 32'(bus.out_idx), m_idx);
    check({tag, "_out_data"}, bus.out_data, m_data);
  endtask

  initial begin
    // Directed table: reset, streaming, backpressure, sparse, wrap, mid-stream reset.
    vecs[0]  = mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0, 32'h00);
    vecs[1]  = mk(1, 4'b1111, 1, 4'b0001, 0, 1, 0, 32'h10);
    vecs[2]  = mk(1, 4'b1111, 1, 4'b0010, 1, 1, 1, 32'h11);
    vecs[3]  = mk(1, 4'b1111, 1, 4'b0100, 2, 1, 2, 32'h12);
    vecs[4]  = mk(1, 4'b1111, 1, 4'b1000, 3, 1, 3, 32'h13);
    vecs[5]  = mk(1, 4'b1111, 1, 4'b0001, 0, 1, 0, 32'h10);
    vecs[6]  = mk(1, 4'b1111, 0, 4'b0000, 1, 1, 0, 32'h10);
    vecs[7]  = mk(1, 4'b1111, 0, 4'b0000, 1, 1, 0, 32'h10);
    vecs[8]  = mk(1, 4'b1111, 0, 4'b0000, 1, 1, 0, 32'h10);
    vecs[9]  = mk(1, 4'b1111, 1, 4'b0010, 1, 1, 1, 32'h11);
    vecs[10] = mk(1, 4'b1010, 1, 4'b1000, 3, 1, 3, 32'h13);
    vecs[11] = mk(1, 4'b1010, 1, 4'b0010, 1, 1, 1, 32'h11);
    vecs[12] = mk(1, 4'b1010, 1, 4'b1000, 3, 1, 3, 32'h13);
    vecs[13] = mk(1, 4'b0000, 1, 4'b0000, 0, 0, 3, 32'h13);
    vecs[14] = mk(1, 4'b1001, 1, 4'b0001, 0, 1, 0, 32'h10);
    vecs[15] = mk(1, 4'b1001, 1, 4'b1000, 3, 1, 3, 32'h13);
    vecs[16] = mk(1, 4'b0000, 1, 4'b0000, 0, 0, 3, 32'h13);
    vecs[17] = mk(1, 4'b1111, 1, 4'b0001, 0, 1, 0, 32'h10);
    vecs[18] = mk(1, 4'b1111, 0, 4'b0000, 1, 1, 0, 32'h10);
    vecs[19] = mk(0, 4'b1111, 0, 4'b0000, 1, 0, 0, 32'h00);
    vecs[20] = mk(1, 4'b0100, 1, 4'b0100, 2, 1, 2, 32'h12);

    set_data(32'h10, 32'h11, 32'h12, 32'h13);
    drive(0, 4'b1111, 1, 4'b0000);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst_n, vecs[i].valid, vecs[i].ordy, 4'b0000);
      #1;
      check($sformatf("vec%0d_req_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_rr));
      check($sformatf("vec%0d_sel", i), 32'(bus.sel), 32'(vecs[i].exp_sel));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d_out_idx", i), 32'(bus.out_idx), 32'(vecs[i].exp_idx));
      check($sformatf("vec%0d_out_data", i), bus.out_data, vecs[i].exp_data);
    end

    // Model picks up from the state the table leaves behind.
    m_ptr = 3; m_ov = 1; m_idx = 2; m_data = 32'h12;

    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 49) != 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
      set_data($urandom, $urandom, $urandom, $urandom);
      mstep("rnd");
    end

`ifdef RR_ARB4_LOCK_EN
    set_data(32'h10, 32'h11, 32'h12, 32'h13);
    drive(0, 4'b0000, 1, 4'b0000);
    mstep("lock_rst");
    begin
      logic [3:0] lk_seq  [6];
      int         idx_seq [6];
      lk_seq  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
      idx_seq = '{0, 1, 2, 2, 2, 3};
      for (int i = 0; i < 6; i++) begin
        drive(1, 4'b1111, 1, lk_seq[i]);
        mstep("lock");
        check($sformatf("lock_seq%0d_idx", i), 32'(bus.out_idx), idx_seq[i]);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
